exec_dispatch_unit: RTL and testbench

- Sits between the decode stage and the ALU exec element; serializes one integer instruction at a time.
- Accepts a decoded instruction over a valid/ready handshake and reads its operands from the GPR file.
- Starts the exec element by pulsing its reset, waits for its completed flag, and writes the result back to the GPR file.
- Provides write-back bypass, a completion watchdog and a retired-instruction counter.

---
 rtl/felis_exec_pkg.sv | 55 +++++
 rtl/exec_watchdog.sv | 38 +++
 rtl/exec_dispatch_unit.sv | 165 ++++++++++++++++
 tb/tb_exec_dispatch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/felis_exec_pkg.sv
// -----------------------------------------------------------------------------
// felis_exec_pkg
// Shared definitions for the integer execute dispatch path:
//   - dispatch_state_t : dispatcher FSM states
//   - dispatch_op_t    : instruction fields and operands held for the element
//   - INST_*           : exec element operation numbers
//   - REG_ZERO         : hard-wired zero register index
//   - sext16           : 16 -> 32 bit sign extension helper
// -----------------------------------------------------------------------------
package felis_exec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } dispatch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  inst_num;
        logic [15:0] const16;
        logic [4:0]  shift5;
        logic [25:0] addr26;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  dest;
        logic        wb_en;
    } dispatch_op_t;

    localparam logic [5:0] INST_ADD  = 6'd8;
    localparam logic [5:0] INST_ADDI = 6'd9;
    localparam logic [5:0] INST_SUB  = 6'd10;
    localparam logic [5:0] INST_LUI  = 6'd11;
    localparam logic [5:0] INST_DIV  = 6'd12;
    localparam logic [5:0] INST_MULT = 6'd13;
    localparam logic [5:0] INST_SLL  = 6'd16;
    localparam logic [5:0] INST_SRA  = 6'd17;
    localparam logic [5:0] INST_SRL  = 6'd18;
    localparam logic [5:0] INST_AND  = 6'd20;
    localparam logic [5:0] INST_ANDI = 6'd21;
    localparam logic [5:0] INST_OR   = 6'd22;
    localparam logic [5:0] INST_ORI  = 6'd23;
    localparam logic [5:0] INST_XOR  = 6'd24;
    localparam logic [5:0] INST_XORI = 6'd25;
    localparam logic [5:0] INST_NOR  = 6'd26;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic signed [31:0] sext16(input logic [15:0] value);
        logic signed [15:0] narrow;
        narrow = $signed(value);
        return 32'(narrow);
    endfunction

endpackage

// File: rtl/exec_watchdog.sv
// -----------------------------------------------------------------------------
// exec_watchdog
// Completion watchdog for the dispatcher. Counts enabled cycles since the last
// clear and raises a combinational expire flag on the enabled cycle in which
// the count has reached TIMEOUT_CYCLES-1.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the count back to zero (has priority over enable)
//   enable     : count this cycle
//   expire     : enable && count == TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module exec_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    import felis_exec_pkg::*;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/exec_dispatch_unit.sv
// -----------------------------------------------------------------------------
// exec_dispatch_unit
// Serialises decoded integer instructions onto a single ALU exec element.
// An accepted instruction has its fields and GPR operands latched (with
// write-back bypass), the element is cleared for one cycle (LAUNCH), and the
// dispatcher then waits for elem_completed to write the result back.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_*                 : decoded instruction, valid/ready handshake
//   rf_raddr_*/rf_rdata_*: GPR asynchronous read port (addresses follow in_*)
//   rf_we/rf_waddr/rf_wdata : GPR write port, driven in the completion cycle
//   elem_*               : exec element control, result and held operands
//   err_timeout          : one-cycle pulse after a watchdog abort
//   retired_count        : completed instructions, wraps
// -----------------------------------------------------------------------------
module exec_dispatch_unit #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [5:0]       in_inst_num,
    input  logic [15:0]      in_const16,
    input  logic [4:0]       in_shift5,
    input  logic [25:0]      in_addr26,
    input  logic [4:0]       in_rs_idx,
    input  logic [4:0]       in_rt_idx,
    input  logic [4:0]       in_dest_idx,
    input  logic             in_wb_en,
    output logic [4:0]       rf_raddr_s,
    output logic [4:0]       rf_raddr_t,
    input  logic [31:0]      rf_rdata_s,
    input  logic [31:0]      rf_rdata_t,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             elem_reset,
    input  logic             elem_completed,
    input  logic [31:0]      elem_out,
    output logic [31:0]      elem_pc,
    output logic [31:0]      elem_const16_x,
    output logic [31:0]      elem_rs,
    output logic [31:0]      elem_rt,
    output logic [5:0]       elem_inst_num,
    output logic [15:0]      elem_const16,
    output logic [4:0]       elem_shift5,
    output logic [25:0]      elem_addr26,
    output logic [31:0]      elem_rd,
    output logic [31:0]      elem_fs,
    output logic [31:0]      elem_ft,
    output logic [31:0]      elem_fd,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired_count
);
    import felis_exec_pkg::*;

    dispatch_state_t state;
    dispatch_op_t    op;
    dispatch_op_t    op_in;
    logic            accept;
    logic            done;
    logic            wd_expire;
    logic            byp_s;
    logic            byp_t;

    assign rf_raddr_s = in_rs_idx;
    assign rf_raddr_t = in_rt_idx;

    assign in_ready = !reset && (state == ST_IDLE || (state == ST_WAIT && elem_completed));
    assign accept   = in_valid && in_ready;

    // Completion is only honoured in WAIT: in LAUNCH the flag may still be
    // high from the previous operation.
    assign done = !reset && (state == ST_WAIT) && elem_completed;

    assign rf_we    = done && op.wb_en && (op.dest != REG_ZERO);
    assign rf_waddr = op.dest;
    assign rf_wdata = elem_out;

    // An instruction accepted in a completion cycle may read a register that
    // the GPR file has not yet written; take the write-back value instead.
    assign byp_s = rf_we && (rf_waddr == in_rs_idx);
    assign byp_t = rf_we && (rf_waddr == in_rt_idx);

    always_comb begin
        op_in          = '0;
        op_in.pc       = in_pc;
        op_in.inst_num = in_inst_num;
        op_in.const16  = in_const16;
        op_in.shift5   = in_shift5;
        op_in.addr26   = in_addr26;
        op_in.rs_val   = byp_s ? rf_wdata : rf_rdata_s;
        op_in.rt_val   = byp_t ? rf_wdata : rf_rdata_t;
        op_in.dest     = in_dest_idx;
        op_in.wb_en    = in_wb_en;
    end

    exec_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_LAUNCH),
        .enable(state == ST_WAIT && !elem_completed),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            op            <= '0;
            err_timeout   <= 1'b0;
            retired_count <= '0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op    <= op_in;
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (elem_completed) begin
                        retired_count <= retired_count + CNT_W'(1);
                        if (accept) begin
                            op    <= op_in;
                            state <= ST_LAUNCH;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (wd_expire) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign elem_reset = reset || (state == ST_LAUNCH);

    assign elem_pc        = op.pc;
    assign elem_const16_x = sext16(op.const16);
    assign elem_rs        = op.rs_val;
    assign elem_rt        = op.rt_val;
    assign elem_inst_num  = op.inst_num;
    assign elem_const16   = op.const16;
    assign elem_shift5    = op.shift5;
    assign elem_addr26    = op.addr26;
    assign elem_rd        = '0;
    assign elem_fs        = '0;
    assign elem_ft        = '0;
    assign elem_fd        = '0;

endmodule

// File: tb/tb_exec_dispatch_unit.sv
module tb_exec_dispatch_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [5:0]  in_inst_num = '0;
    logic [15:0] in_const16 = '0;
    logic [4:0]  in_shift5 = '0;
    logic [25:0] in_addr26 = '0;
    logic [4:0]  in_rs_idx = '0;
    logic [4:0]  in_rt_idx = '0;
    logic [4:0]  in_dest_idx = '0;
    logic        in_wb_en = 1'b0;
    logic [4:0]  rf_raddr_s, rf_raddr_t;
    logic [31:0] rf_rdata_s, rf_rdata_t;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        elem_reset;
    logic        elem_completed;
    logic [31:0] elem_out;
    logic [31:0] elem_pc, elem_const16_x, elem_rs, elem_rt;
    logic [5:0]  elem_inst_num;
    logic [15:0] elem_const16;
    logic [4:0]  elem_shift5;
    logic [25:0] elem_addr26;
    logic [31:0] elem_rd, elem_fs, elem_ft, elem_fd;
    logic        err_timeout;
    logic [31:0] retired_count;

    exec_dispatch_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst_num(in_inst_num), .in_const16(in_const16),
        .in_shift5(in_shift5), .in_addr26(in_addr26), .in_rs_idx(in_rs_idx),
        .in_rt_idx(in_rt_idx), .in_dest_idx(in_dest_idx), .in_wb_en(in_wb_en),
        .rf_raddr_s(rf_raddr_s), .rf_raddr_t(rf_raddr_t),
        .rf_rdata_s(rf_rdata_s), .rf_rdata_t(rf_rdata_t),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .elem_reset(elem_reset), .elem_completed(elem_completed), .elem_out(elem_out),
        .elem_pc(elem_pc), .elem_const16_x(elem_const16_x), .elem_rs(elem_rs),
        .elem_rt(elem_rt), .elem_inst_num(elem_inst_num), .elem_const16(elem_const16),
        .elem_shift5(elem_shift5), .elem_addr26(elem_addr26),
        .elem_rd(elem_rd), .elem_fs(elem_fs), .elem_ft(elem_ft), .elem_fd(elem_fd),
        .err_timeout(err_timeout), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Architectural meaning of each operation number.
    function automatic logic [31:0] alu(input logic [5:0] inst, input logic [31:0] a,
                                        input logic [31:0] b, input logic [15:0] imm,
                                        input logic [4:0] sh);
        logic [31:0] sx, zx;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0000, imm};
        case (inst)
            6'd8:  return a + b;
            6'd9:  return a + sx;
            6'd10: return a - b;
            6'd11: return {imm, 16'h0000};
            6'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            6'd13: return a * b;
            6'd16: return b << sh;
            6'd17: return $unsigned($signed(b) >>> sh);
            6'd18: return b >> sh;
            6'd20: return a & b;
            6'd21: return a & zx;
            6'd22: return a | b;
            6'd23: return a | zx;
            6'd24: return a ^ b;
            6'd25: return a ^ zx;
            6'd26: return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    // GPR file: async read, write on clock edge; bench can preload it.
    logic [31:0] gpr [32];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_waddr = '0;
    logic [31:0] tb_wdata = '0;
    initial for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    always @(posedge clk) begin
        if (rf_we) gpr[rf_waddr] <= rf_wdata;
        else if (tb_we && tb_waddr != 0) gpr[tb_waddr] <= tb_wdata;
    end
    assign rf_rdata_s = gpr[rf_raddr_s];
    assign rf_rdata_t = gpr[rf_raddr_t];

    // Exec element stub: cleared by elem_reset, completes stub_lat cycles
    // later and holds completed high until the next clear.
    logic        elem_done = 1'b0;
    logic [31:0] elem_res = '0;
    int          stub_cnt = 0;
    int          stub_lat = 1;
    int          lat_next = 1;
    bit          hang = 1'b0;
    always @(posedge clk) begin
        if (elem_reset) begin
            elem_done <= 1'b0;
            stub_cnt  <= 0;
            stub_lat  <= lat_next;
        end else if (!elem_done && !hang) begin
            if (stub_cnt + 1 >= stub_lat) begin
                elem_done <= 1'b1;
                elem_res  <= alu(elem_inst_num, elem_rs, elem_rt, elem_const16, elem_shift5);
            end
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign elem_completed = elem_done;
    assign elem_out       = elem_res;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic drive(input logic [5:0] inst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic wb, input logic [15:0] imm,
                         input logic [4:0] sh);
        in_valid = 1'b1; in_inst_num = inst; in_rs_idx = rs; in_rt_idx = rt;
        in_dest_idx = dst; in_wb_en = wb; in_const16 = imm; in_shift5 = sh;
        in_pc = $urandom; in_addr26 = 26'($urandom);
    endtask

    logic [31:0] mreg [32];
    logic [4:0]  exp_a [$];
    logic [31:0] exp_d [$];
    logic [5:0]  ops [16] = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd16, 6'd17,
                              6'd18, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26};

    initial begin
        int  issued;
        bit  have, acc;
        int  hold_lat;
        logic [31:0] res;

        // Reset state
        lat_next = 1;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_elem_reset", elem_reset, 1);
        check("rst_rf_we", rf_we, 0);
        check("rst_retired", retired_count, 0);
        check("rst_err_timeout", err_timeout, 0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_elem_reset", elem_reset, 0);
        check("fp_zero", elem_rd | elem_fs | elem_ft | elem_fd, 0);

        // ADD r3 = r1 + r2, latency check
        poke(5'd1, 32'd5);
        poke(5'd2, 32'd7);
        drive(6'd8, 5'd1, 5'd2, 5'd3, 1'b1, 16'h0, 5'd0);
        tick(); in_valid = 1'b0;
        check("add_launch_reset", elem_reset, 1);
        tick();
        check("add_wait_reset", elem_reset, 0);
        check("add_wait_we", rf_we, 0);
        tick();
        check("add_we", rf_we, 1);
        check("add_waddr", rf_waddr, 3);
        check("add_wdata", rf_wdata, 12);
        tick();
        check("add_retired", retired_count, 1);

        // ADDI r4 = r1 + sext(0xFFFE)
        drive(6'd9, 5'd1, 5'd0, 5'd4, 1'b1, 16'hFFFE, 5'd0);
        tick(); in_valid = 1'b0;
        check("addi_const16_x", elem_const16_x, 32'hFFFF_FFFE);
        tick(); tick();
        check("addi_we", rf_we, 1);
        check("addi_wdata", rf_wdata, 3);
        tick();

        // Back-to-back with bypass: r3 holds a stale 99 in the GPR file
        poke(5'd3, 32'd99);
        drive(6'd8, 5'd1, 5'd2, 5'd3, 1'b1, 16'h0, 5'd0);
        tick(); in_valid = 1'b0;
        tick(); tick();
        check("byp_first_wdata", rf_wdata, 12);
        check("byp_in_ready", in_ready, 1);
        drive(6'd9, 5'd3, 5'd0, 5'd4, 1'b1, 16'h0001, 5'd0);
        tick(); in_valid = 1'b0;
        check("byp_launch", elem_reset, 1);
        check("byp_elem_rs", elem_rs, 12);
        tick(); tick();
        check("byp_we", rf_we, 1);
        check("byp_waddr", rf_waddr, 4);
        check("byp_wdata", rf_wdata, 13);
        tick();
        check("byp_retired", retired_count, 4);

        // Destination r0: no write, still retired
        drive(6'd8, 5'd1, 5'd2, 5'd0, 1'b1, 16'h0, 5'd0);
        tick(); in_valid = 1'b0;
        tick(); tick();
        check("r0_we", rf_we, 0);
        tick();
        check("r0_retired", retired_count, 5);

        // Watchdog abort
        hang = 1'b1;
        drive(6'd8, 5'd1, 5'd2, 5'd5, 1'b1, 16'h0, 5'd0);
        tick(); in_valid = 1'b0;
        for (int k = 0; k < TO; k++) begin
            tick();
            check("wd_no_err", err_timeout, 0);
            check("wd_no_we", rf_we, 0);
        end
        tick();
        check("wd_err", err_timeout, 1);
        check("wd_ready", in_ready, 1);
        tick();
        check("wd_err_drop", err_timeout, 0);
        check("wd_retired", retired_count, 5);
        hang = 1'b0;

        // Reset in the completion cycle
        drive(6'd8, 5'd1, 5'd2, 5'd6, 1'b1, 16'h0, 5'd0);
        tick(); in_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("rstw_we", rf_we, 0);
        check("rstw_elem_reset", elem_reset, 1);
        check("rstw_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rstw_idle_ready", in_ready, 1);
        check("rstw_retired", retired_count, 0);
        check("rstw_no_write", gpr[6], 0);

        // Randomised program against an in-order architectural model
        mreg[0] = 32'h0;
        for (int r = 1; r < 32; r++) begin
            mreg[r] = $urandom;
            poke(5'(r), mreg[r]);
        end
        issued = 0; have = 0; acc = 0; hold_lat = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (rf_we) begin
                if (exp_a.size() == 0) check("rnd_unexpected_we", 32'd1, 32'd0);
                else begin
                    check("rnd_waddr", rf_waddr, exp_a.pop_front());
                    check("rnd_wdata", rf_wdata, exp_d.pop_front());
                end
            end
            if (err_timeout) check("rnd_err_timeout", err_timeout, 0);
            if (acc) begin
                lat_next = hold_lat;
                res = alu(in_inst_num, mreg[in_rs_idx], mreg[in_rt_idx], in_const16, in_shift5);
                if (in_wb_en && in_dest_idx != 0) begin
                    mreg[in_dest_idx] = res;
                    exp_a.push_back(in_dest_idx);
                    exp_d.push_back(res);
                end
                issued++;
                in_valid = 1'b0;
                have = 0;
            end
            if (!have && cyc < 2960 && $urandom_range(0, 2) != 0) begin
                drive(ops[$urandom_range(0, 15)], 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 5) != 0), 16'($urandom), 5'($urandom));
                hold_lat = $urandom_range(1, 4);
                have = 1;
            end
            #1;
            acc = in_valid && in_ready;
        end
        check("rnd_drained", exp_a.size(), 0);
        check("rnd_retired", retired_count, issued);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
